// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// FSM state encoding and small decode helpers.
package mdu_pkg;

   localparam logic [1:0] FN_MULT  = 2'b00;
   localparam logic [1:0] FN_MULTU = 2'b01;
   localparam logic [1:0] FN_DIV   = 2'b10;
   localparam logic [1:0] FN_DIVU  = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

   function automatic logic is_signed_op(input logic [1:0] fn);
      return ~fn[0];
   endfunction

   function automatic logic is_div_op(input logic [1:0] fn);
      return fn[1];
   endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of shift-add multiply or restoring divide on the {acc, q} pair.
// m_i is the multiplier/divisor magnitude.
module mdu_iter_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
      shifted = {acc_i, q_i[WIDTH-1]};
      // Partial remainder is always below 2*m, so the difference fits in WIDTH bits.
      diff    = WIDTH'(shifted - {1'b0, m_i});
      if (is_div_i) begin
         if (shifted >= {1'b0, m_i}) begin
            acc_o = diff;
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = shifted[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = sum[WIDTH:1];
         q_o   = {sum[0], q_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: latch magnitudes, run WIDTH
// iterations, then apply sign correction and write HI/LO in a final FIX cycle.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       Func,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_div_q;
   logic             neg_q;
   logic             rem_neg_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] in1_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             op_signed;
   logic [WIDTH-1:0] in1_mag;
   logic [WIDTH-1:0] in2_mag;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] q_d;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;
   logic               res_dbz;

   assign op_signed = is_signed_op(Func);
   assign in1_mag   = (op_signed && In1[WIDTH-1]) ? -In1 : In1;
   assign in2_mag   = (op_signed && In2[WIDTH-1]) ? -In2 : In2;

   mdu_iter_step #(
      .WIDTH(WIDTH)
   ) u_iter_step (
      .is_div_i(is_div_q),
      .acc_i   (acc_q),
      .q_i     (q_q),
      .m_i     (m_q),
      .acc_o   (acc_d),
      .q_o     (q_d)
   );

   always_comb begin
      prod_fix = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      res_dbz  = 1'b0;
      if (is_div_q) begin
         if (m_q == '0) begin
            res_hi  = in1_q;
            res_lo  = '1;
            res_dbz = 1'b1;
         end else begin
            res_hi = rem_neg_q ? -acc_q : acc_q;
            res_lo = neg_q ? -q_q : q_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         acc_q     <= '0;
         q_q       <= '0;
         m_q       <= '0;
         in1_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !flush) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  is_div_q  <= is_div_op(Func);
                  neg_q     <= op_signed & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                  rem_neg_q <= op_signed & In1[WIDTH-1];
                  acc_q     <= '0;
                  q_q       <= in1_mag;
                  m_q       <= in2_mag;
                  in1_q     <= In1;
               end else if (!start) begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            RUN: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  q_q   <= q_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LastIter) state_q <= FIX;
               end
            end
            FIX: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (!flush) begin
                  hi_q   <= res_hi;
                  lo_q   <= res_lo;
                  dbz_q  <= res_dbz;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign HI          = hi_q;
   assign LO          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  Func;
   logic [31:0] In1;
   logic [31:0] In2;
   logic        flush;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_err = 0;

   mult_div_unit #(
      .WIDTH(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .Func       (Func),
      .In1        (In1),
      .In2        (In2),
      .flush      (flush),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .HI         (HI),
      .LO         (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch an op and wait (bounded) for done; optionally re-assert start mid-op.
   task automatic run_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int restart_at, output int busy_cnt, output logic got_done);
      @(negedge clk);
      Func = fn; In1 = a; In2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_cnt = 0;
      got_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         if (i == restart_at) begin
            start = 1'b1; Func = FN_MULTU; In1 = 32'd9; In2 = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp += 5;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      if (div_by_zero !== 1'b0) begin
         n_err++; $display("FAIL reset_dbz: got %b want 0", div_by_zero);
      end
      if (HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", HI); end
      if (LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", LO); end
      rst_n = 1'b1;
   endtask

   task automatic test_mult_signed();
      int bc; logic gd;
      run_op(FN_MULT, 32'hFFFFFFFD, 32'd7, -1, bc, gd);
      n_cmp += 5;
      if (gd !== 1'b1) begin n_err++; $display("FAIL mult_done: got %b want 1", gd); end
      if (bc != 33) begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
      if (HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      if (LO !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo: got %h want ffffffeb", LO); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_multu_divu();
      int bc; logic gd;
      run_op(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, bc, gd);
      n_cmp += 3;
      if (gd !== 1'b1) begin n_err++; $display("FAIL multu_done: got %b want 1", gd); end
      if (HI !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
      if (LO !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", LO); end
      run_op(FN_DIVU, 32'd129838, 32'd3412, -1, bc, gd);
      n_cmp += 4;
      if (gd !== 1'b1) begin n_err++; $display("FAIL divu_done: got %b want 1", gd); end
      if (LO !== 32'h26) begin n_err++; $display("FAIL divu_lo: got %h want 00000026", LO); end
      if (HI !== 32'hB6) begin n_err++; $display("FAIL divu_hi: got %h want 000000b6", HI); end
      if (div_by_zero !== 1'b0) begin
         n_err++; $display("FAIL divu_dbz: got %b want 0", div_by_zero);
      end
   endtask

   task automatic test_div_signed();
      int bc; logic gd;
      run_op(FN_DIV, 32'hFFFFFFF9, 32'd2, -1, bc, gd);
      n_cmp += 3;
      if (gd !== 1'b1) begin n_err++; $display("FAIL div_done: got %b want 1", gd); end
      if (LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", LO); end
      if (HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", HI); end
      run_op(FN_DIV, 32'h80000000, 32'hFFFFFFFF, -1, bc, gd);
      n_cmp += 3;
      if (LO !== 32'h80000000) begin n_err++; $display("FAIL divmin_lo: got %h want 80000000", LO); end
      if (HI !== 32'h0) begin n_err++; $display("FAIL divmin_hi: got %h want 00000000", HI); end
      if (div_by_zero !== 1'b0) begin
         n_err++; $display("FAIL divmin_dbz: got %b want 0", div_by_zero);
      end
   endtask

   task automatic test_div_zero();
      int bc; logic gd;
      run_op(FN_DIVU, 32'h1234, 32'h0, -1, bc, gd);
      n_cmp += 4;
      if (bc != 33) begin n_err++; $display("FAIL dbz_busy_cycles: got %0d want 33", bc); end
      if (LO !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dbz_lo: got %h want ffffffff", LO); end
      if (HI !== 32'h1234) begin n_err++; $display("FAIL dbz_hi: got %h want 00001234", HI); end
      if (div_by_zero !== 1'b1) begin
         n_err++; $display("FAIL dbz_flag: got %b want 1", div_by_zero);
      end
      run_op(FN_MULTU, 32'd2, 32'd3, -1, bc, gd);
      n_cmp += 3;
      if (HI !== 32'h0) begin n_err++; $display("FAIL dbz_next_hi: got %h want 00000000", HI); end
      if (LO !== 32'h6) begin n_err++; $display("FAIL dbz_next_lo: got %h want 00000006", LO); end
      if (div_by_zero !== 1'b0) begin
         n_err++; $display("FAIL dbz_clear: got %b want 0", div_by_zero);
      end
   endtask

   task automatic test_back_to_back();
      int bc; logic gd;
      // Second start (9*9) during busy must not disturb the 7*11 in flight.
      run_op(FN_MULTU, 32'd7, 32'd11, 8, bc, gd);
      n_cmp += 3;
      if (bc != 33) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 33", bc); end
      if (LO !== 32'd77) begin n_err++; $display("FAIL b2b_lo: got %h want 0000004d", LO); end
      if (HI !== 32'h0) begin n_err++; $display("FAIL b2b_hi: got %h want 00000000", HI); end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_restart: got %b want 0", busy); end
   endtask

   task automatic test_flush();
      logic seen;
      @(negedge clk); hi_we = 1'b1; wdata = 32'hA;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hB;
      @(negedge clk); lo_we = 1'b0;
      n_cmp += 2;
      if (HI !== 32'hA) begin n_err++; $display("FAIL mthi: got %h want 0000000a", HI); end
      if (LO !== 32'hB) begin n_err++; $display("FAIL mtlo: got %h want 0000000b", LO); end
      Func = FN_MULT; In1 = 32'd5; In2 = 32'd5; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; In1 = 32'd3; In2 = 32'd4;
      @(negedge clk); start = 1'b0; hi_we = 1'b1; wdata = 32'h55;
      @(negedge clk); hi_we = 1'b0;
      n_cmp++;
      if (HI !== 32'hA) begin n_err++; $display("FAIL hi_we_busy: got %h want 0000000a", HI); end
      repeat (7) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      n_cmp += 4;
      if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b want 0", done); end
      if (HI !== 32'hA) begin n_err++; $display("FAIL flush_hi: got %h want 0000000a", HI); end
      if (LO !== 32'hB) begin n_err++; $display("FAIL flush_lo: got %h want 0000000b", LO); end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_err++; $display("FAIL flush_quiet: got %b want 0", seen); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      @(negedge clk);
      Func = FN_DIV; In1 = 32'd100; In2 = 32'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp += 4;
      if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
      if (HI !== 32'h0) begin n_err++; $display("FAIL rstmid_hi: got %h want 00000000", HI); end
      if (LO !== 32'h0) begin n_err++; $display("FAIL rstmid_lo: got %h want 00000000", LO); end
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet: got %b want 0", seen); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; Func = 2'b00; In1 = '0; In2 = '0;
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      test_reset();
      test_mult_signed();
      test_multu_divu();
      test_div_signed();
      test_div_zero();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
